// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port arbiter in front of the shared 128 KiB video RAM.
// Video scanout has strict priority, capped by an anti-starvation run limit;
// CPU and the line-drawing accelerator share the leftover slots round-robin.
// One access issues per cycle. The RAM port is registered, and read data is
// routed back to its requester through a one-entry tag pipeline.
module vram_arbiter #(
  parameter int unsigned VID_RUN = 8
) (
  input  logic        clock,
  input  logic        reset,
  // video scanout (read only)
  input  logic        vid_req,
  input  logic [16:0] vid_a,
  output logic        vid_ack,
  output logic [7:0]  vid_i,
  output logic        vid_dv,
  // CPU
  input  logic        cpu_req,
  input  logic [16:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  output logic        cpu_ack,
  output logic [7:0]  cpu_i,
  output logic        cpu_dv,
  // line-drawing accelerator
  input  logic        acc_req,
  input  logic [16:0] acc_a,
  input  logic [7:0]  acc_o,
  input  logic        acc_w,
  output logic        acc_ack,
  output logic [7:0]  acc_i,
  output logic        acc_dv,
  // RAM port
  output logic [16:0] mem_a,
  output logic [7:0]  mem_o,
  output logic        mem_w,
  input  logic [7:0]  mem_i
);

  localparam logic [3:0] RUN_MAX = 4'(VID_RUN);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2,
    TAG_ACC  = 2'd3
  } tag_e;

  // Arbitration state
  logic [3:0]  run_q, run_d;
  logic        rr_q, rr_d;

  // Issue stage (RAM port and tag of the access in flight)
  logic [16:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_o_q, mem_o_d;
  logic        mem_w_q, mem_w_d;
  tag_e        tag_q, tag_d;
  logic        rd_q, rd_d;

  // Return stage (per-requester read data and valid pulse)
  logic [7:0]  vid_i_q, vid_i_d;
  logic [7:0]  cpu_i_q, cpu_i_d;
  logic [7:0]  acc_i_q, acc_i_d;
  logic        vid_dv_q, vid_dv_d;
  logic        cpu_dv_q, cpu_dv_d;
  logic        acc_dv_q, acc_dv_d;

  // Grant decode
  logic        others_wait;
  logic        vid_blocked;
  logic        vid_gnt, cpu_gnt, acc_gnt;

  // Saturating increment of the video run counter.
  function automatic logic [3:0] run_sat_inc(input logic [3:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + 4'd1;
  endfunction

  // Combinational grant: video first unless its run limit is hit, then round-robin.
  always_comb begin
    others_wait = cpu_req | acc_req;
    vid_blocked = (run_q == RUN_MAX) && others_wait;
    vid_gnt     = 1'b0;
    cpu_gnt     = 1'b0;
    acc_gnt     = 1'b0;
    if (!reset) begin
      if (vid_req && !vid_blocked) begin
        vid_gnt = 1'b1;
      end else if (cpu_req && acc_req) begin
        if (rr_q) acc_gnt = 1'b1;
        else      cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (acc_req) begin
        acc_gnt = 1'b1;
      end
    end
  end

  assign vid_ack = vid_gnt;
  assign cpu_ack = cpu_gnt;
  assign acc_ack = acc_gnt;

  // Next state for run counter, round-robin pointer and the issue stage.
  always_comb begin
    run_d   = (vid_gnt && others_wait) ? run_sat_inc(run_q) : 4'd0;
    rr_d    = rr_q;
    mem_a_d = mem_a_q;
    mem_o_d = mem_o_q;
    mem_w_d = 1'b0;
    tag_d   = TAG_NONE;
    rd_d    = 1'b0;
    if (vid_gnt) begin
      mem_a_d = vid_a;
      tag_d   = TAG_VID;
      rd_d    = 1'b1;
    end else if (cpu_gnt) begin
      rr_d    = 1'b1;
      mem_a_d = cpu_a;
      mem_o_d = cpu_o;
      mem_w_d = cpu_w;
      tag_d   = TAG_CPU;
      rd_d    = !cpu_w;
    end else if (acc_gnt) begin
      rr_d    = 1'b0;
      mem_a_d = acc_a;
      mem_o_d = acc_o;
      mem_w_d = acc_w;
      tag_d   = TAG_ACC;
      rd_d    = !acc_w;
    end
  end

  // Next state for the return stage: steer mem_i to the tagged requester on reads.
  always_comb begin
    vid_dv_d = rd_q && (tag_q == TAG_VID);
    cpu_dv_d = rd_q && (tag_q == TAG_CPU);
    acc_dv_d = rd_q && (tag_q == TAG_ACC);
    vid_i_d  = vid_dv_d ? mem_i : vid_i_q;
    cpu_i_d  = cpu_dv_d ? mem_i : cpu_i_q;
    acc_i_d  = acc_dv_d ? mem_i : acc_i_q;
  end

  // Arbitration state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q <= 4'd0;
      rr_q  <= 1'b0;
    end else begin
      run_q <= run_d;
      rr_q  <= rr_d;
    end
  end

  // ---- issue stage: RAM port presented during the cycle after the grant ----
  // Issue registers; reset drops mem_w at once and discards the tag in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_a_q <= 17'd0;
      mem_o_q <= 8'd0;
      mem_w_q <= 1'b0;
      tag_q   <= TAG_NONE;
      rd_q    <= 1'b0;
    end else begin
      mem_a_q <= mem_a_d;
      mem_o_q <= mem_o_d;
      mem_w_q <= mem_w_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
    end
  end

  // ---- return stage: read data and dv pulse two cycles after the grant ----
  // Return registers; x_i holds until the next read for that requester.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vid_i_q  <= 8'd0;
      cpu_i_q  <= 8'd0;
      acc_i_q  <= 8'd0;
      vid_dv_q <= 1'b0;
      cpu_dv_q <= 1'b0;
      acc_dv_q <= 1'b0;
    end else begin
      vid_i_q  <= vid_i_d;
      cpu_i_q  <= cpu_i_d;
      acc_i_q  <= acc_i_d;
      vid_dv_q <= vid_dv_d;
      cpu_dv_q <= cpu_dv_d;
      acc_dv_q <= acc_dv_d;
    end
  end

  assign mem_a  = mem_a_q;
  assign mem_o  = mem_o_q;
  assign mem_w  = mem_w_q;
  assign vid_i  = vid_i_q;
  assign cpu_i  = cpu_i_q;
  assign acc_i  = acc_i_q;
  assign vid_dv = vid_dv_q;
  assign cpu_dv = cpu_dv_q;
  assign acc_dv = acc_dv_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 128 KiB RAM behind it.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [16:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_i;
  logic        vid_dv;
  logic        cpu_req;
  logic [16:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic        cpu_ack;
  logic [7:0]  cpu_i;
  logic        cpu_dv;
  logic        acc_req;
  logic [16:0] acc_a;
  logic [7:0]  acc_o;
  logic        acc_w;
  logic        acc_ack;
  logic [7:0]  acc_i;
  logic        acc_dv;
  logic [16:0] mem_a;
  logic [7:0]  mem_o;
  logic        mem_w;
  logic [7:0]  mem_i;

  // RAM model: combinational read of the registered address, write on the edge.
  logic [7:0]  ram [0:131071];
  logic        pl_en;
  logic [16:0] pl_a;
  logic [7:0]  pl_d;

  int n_vec = 0;
  int n_mis = 0;

  vram_arbiter #(.VID_RUN(8)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_i(vid_i), .vid_dv(vid_dv),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w),
    .cpu_ack(cpu_ack), .cpu_i(cpu_i), .cpu_dv(cpu_dv),
    .acc_req(acc_req), .acc_a(acc_a), .acc_o(acc_o), .acc_w(acc_w),
    .acc_ack(acc_ack), .acc_i(acc_i), .acc_dv(acc_dv),
    .mem_a(mem_a), .mem_o(mem_o), .mem_w(mem_w), .mem_i(mem_i)
  );

  always #5 clock = ~clock;

  assign mem_i = ram[mem_a];

  always @(posedge clock) begin
    if (pl_en)      ram[pl_a]  <= pl_d;
    else if (mem_w) ram[mem_a] <= mem_o;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0; vid_a = 17'd0;
    cpu_req = 1'b0; cpu_a = 17'd0; cpu_o = 8'd0; cpu_w = 1'b0;
    acc_req = 1'b0; acc_a = 17'd0; acc_o = 8'd0; acc_w = 1'b0;
  endtask

  logic [7:0] rr_cpu_ack, rr_acc_ack, rr_cpu_dv, rr_acc_dv;

  initial begin
    reset = 1'b1;
    pl_en = 1'b0;
    pl_a  = 17'd0;
    pl_d  = 8'd0;
    idle_inputs();

    // Preload while held in reset.
    preload(17'h01234, 8'h5A);
    preload(17'h00100, 8'h3C);
    preload(17'h00010, 8'h11);
    preload(17'h00020, 8'h22);
    preload(17'h00500, 8'h5E);

    // Reset state: all outputs zero, no ack even with every request high.
    vid_req = 1'b1; cpu_req = 1'b1; acc_req = 1'b1;
    settle();
    check_vec("rst_acks", 32'({vid_ack, cpu_ack, acc_ack}), 32'd0);
    check_vec("rst_mem_a", 32'(mem_a), 32'd0);
    check_vec("rst_mem_o", 32'(mem_o), 32'd0);
    check_vec("rst_mem_w", 32'(mem_w), 32'd0);
    check_vec("rst_data", 32'({vid_i, cpu_i, acc_i}), 32'd0);
    check_vec("rst_dv", 32'({vid_dv, cpu_dv, acc_dv}), 32'd0);
    step();
    idle_inputs();
    reset = 1'b0;

    // CPU read of 0x01234 -> 0x5A two cycles after ack.
    cpu_req = 1'b1; cpu_a = 17'h01234; cpu_w = 1'b0;
    settle();
    check_vec("rd_cpu_ack", 32'({vid_ack, cpu_ack, acc_ack}), 32'b010);
    step();
    cpu_req = 1'b0;
    settle();
    check_vec("rd_mem_a", 32'(mem_a), 32'h01234);
    check_vec("rd_mem_w", 32'(mem_w), 32'd0);
    check_vec("rd_dv_early", 32'(cpu_dv), 32'd0);
    step();
    settle();
    check_vec("rd_dv", 32'(cpu_dv), 32'd1);
    check_vec("rd_data", 32'(cpu_i), 32'h5A);
    step();
    settle();
    check_vec("rd_dv_pulse", 32'(cpu_dv), 32'd0);
    check_vec("rd_data_hold", 32'(cpu_i), 32'h5A);
    step();

    // Reset during N+1 of a CPU read: no dv, outputs cleared.
    cpu_req = 1'b1; cpu_a = 17'h00100;
    settle();
    check_vec("mr_ack", 32'(cpu_ack), 32'd1);
    step();
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    check_vec("mr_mem_w", 32'(mem_w), 32'd0);
    check_vec("mr_mem_a", 32'(mem_a), 32'd0);
    settle();
    check_vec("mr_dv0", 32'(cpu_dv), 32'd0);
    check_vec("mr_cpu_i", 32'(cpu_i), 32'd0);
    step();
    settle();
    check_vec("mr_dv1", 32'(cpu_dv), 32'd0);
    step();
    reset = 1'b0;
    settle();
    check_vec("mr_dv2", 32'(cpu_dv), 32'd0);
    step();
    settle();
    check_vec("mr_dv3", 32'(cpu_dv), 32'd0);
    step();

    // Round-robin: both held 6 cycles -> C A C A C A, dv two cycles later.
    rr_cpu_ack = 8'b0001_0101;
    rr_acc_ack = 8'b0010_1010;
    rr_cpu_dv  = 8'b0101_0100;
    rr_acc_dv  = 8'b1010_1000;
    cpu_a = 17'h00010;
    acc_a = 17'h00020;
    for (int i = 0; i < 8; i++) begin
      cpu_req = (i < 6);
      acc_req = (i < 6);
      settle();
      check_vec($sformatf("rr_cpu_ack%0d", i), 32'(cpu_ack), 32'(rr_cpu_ack[i]));
      check_vec($sformatf("rr_acc_ack%0d", i), 32'(acc_ack), 32'(rr_acc_ack[i]));
      check_vec($sformatf("rr_cpu_dv%0d", i), 32'(cpu_dv), 32'(rr_cpu_dv[i]));
      check_vec($sformatf("rr_acc_dv%0d", i), 32'(acc_dv), 32'(rr_acc_dv[i]));
      if (rr_cpu_dv[i]) check_vec($sformatf("rr_cpu_i%0d", i), 32'(cpu_i), 32'h11);
      if (rr_acc_dv[i]) check_vec($sformatf("rr_acc_i%0d", i), 32'(acc_i), 32'h22);
      step();
    end
    idle_inputs();

    // Write path: ACC writes 0x77 to 0x1FFFF, CPU reads it back next cycle.
    acc_req = 1'b1; acc_w = 1'b1; acc_a = 17'h1FFFF; acc_o = 8'h77;
    settle();
    check_vec("wr_acc_ack", 32'({vid_ack, cpu_ack, acc_ack}), 32'b001);
    step();
    acc_req = 1'b0; acc_w = 1'b0;
    cpu_req = 1'b1; cpu_w = 1'b0; cpu_a = 17'h1FFFF;
    settle();
    check_vec("wr_cpu_ack", 32'(cpu_ack), 32'd1);
    check_vec("wr_mem_w", 32'(mem_w), 32'd1);
    check_vec("wr_mem_a", 32'(mem_a), 32'h1FFFF);
    check_vec("wr_mem_o", 32'(mem_o), 32'h77);
    step();
    cpu_req = 1'b0;
    settle();
    check_vec("wr_mem_w_drop", 32'(mem_w), 32'd0);
    check_vec("wr_acc_dv0", 32'(acc_dv), 32'd0);
    step();
    settle();
    check_vec("wr_cpu_dv", 32'(cpu_dv), 32'd1);
    check_vec("wr_cpu_i", 32'(cpu_i), 32'h77);
    check_vec("wr_acc_dv1", 32'(acc_dv), 32'd0);
    step();
    idle_inputs();

    // Starvation limit: 8 video grants, 1 CPU grant, repeating every 9 cycles.
    vid_req = 1'b1; vid_a = 17'h00500;
    cpu_req = 1'b1; cpu_a = 17'h00010; cpu_w = 1'b0;
    for (int i = 0; i < 18; i++) begin
      settle();
      check_vec($sformatf("st_vid_ack%0d", i), 32'(vid_ack), 32'((i % 9) != 8));
      check_vec($sformatf("st_cpu_ack%0d", i), 32'(cpu_ack), 32'((i % 9) == 8));
      check_vec($sformatf("st_acc_ack%0d", i), 32'(acc_ack), 32'd0);
      step();
    end

    // Dropped request: CPU asks for one cycle while video wins, then lets go.
    settle();
    check_vec("dr_vid_ack", 32'(vid_ack), 32'd1);
    check_vec("dr_cpu_ack", 32'(cpu_ack), 32'd0);
    step();
    idle_inputs();
    settle();
    check_vec("dr_acks", 32'({vid_ack, cpu_ack, acc_ack}), 32'd0);
    check_vec("dr_mem_a", 32'(mem_a), 32'h00500);
    check_vec("dr_mem_w", 32'(mem_w), 32'd0);
    step();
    settle();
    check_vec("dr_mem_hold", 32'(mem_a), 32'h00500);
    check_vec("dr_mem_w2", 32'(mem_w), 32'd0);
    check_vec("dr_cpu_dv", 32'(cpu_dv), 32'd0);
    check_vec("dr_vid_dv", 32'(vid_dv), 32'd1);
    check_vec("dr_vid_i", 32'(vid_i), 32'h5E);
    step();
    // Last CPU grant left rr pointing at ACC; the dropped request must not move it.
    cpu_req = 1'b1; cpu_a = 17'h00010;
    acc_req = 1'b1; acc_a = 17'h00020;
    settle();
    check_vec("dr_rr_acc", 32'(acc_ack), 32'd1);
    check_vec("dr_rr_cpu", 32'(cpu_ack), 32'd0);
    step();
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
